// File: rtl/memory_stage.sv
// Memory-access stage: data memory, stack pointer, and a two-cycle sequencer
// that pushes/pops a 32-bit PC as two 16-bit words for CALL/INT and RET/RTI.
module memory_stage #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] SP_INIT    = {ADDR_WIDTH{1'b1}}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ie_Rdst,
  input  logic [15:0] ie_result,
  input  logic [15:0] ie_read_data1,
  input  logic        ie_MEM_Write,
  input  logic        ie_MEM_Read,
  input  logic        ie_STACK_SIGNAL,
  input  logic        ie_DEC_SP,
  input  logic        ie_INC_SP,
  input  logic        ie_PUSH_PC,
  input  logic        ie_POP_PC,
  input  logic [31:0] ie_PC,
  input  logic        ie_MEM_to_REG,
  input  logic        ie_WRITE_PORT,
  input  logic        ie_REG_Write,
  output logic [2:0]  im_Rdst,
  output logic [15:0] im_result,
  output logic [15:0] im_read_data,
  output logic        im_MEM_to_REG,
  output logic        im_WRITE_PORT,
  output logic        im_REG_Write,
  output logic        mem_stall,
  output logic [31:0] ret_pc,
  output logic        ret_pc_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_PUSH2, S_POP2} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_sp;
  logic [ADDR_WIDTH-1:0] w_sp_nxt;
  logic [ADDR_WIDTH-1:0] w_sp_inc;
  logic [ADDR_WIDTH-1:0] w_sp_dec;
  logic [15:0]           r_hi;
  logic [15:0]           r_mem [DEPTH];

  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [15:0]           w_wdata;
  logic                  w_hi_ld;
  logic                  w_stall;
  logic                  w_ret_vld;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [15:0]           w_rd_sp;
  logic                  w_plain_push;
  logic                  w_plain_pop;

  assign w_sp_inc     = r_sp + 1'b1;
  assign w_sp_dec     = r_sp - 1'b1;
  assign w_plain_push = ie_STACK_SIGNAL & ie_DEC_SP & ie_MEM_Write;
  assign w_plain_pop  = ie_STACK_SIGNAL & ie_INC_SP & ie_MEM_Read;

  // Stack reads are pre-increment, so the top of stack lives at SP+1.
  assign w_rd_addr = ie_STACK_SIGNAL ? w_sp_inc : ie_result[ADDR_WIDTH-1:0];
  assign w_rd_sp   = r_mem[w_sp_inc];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; PUSH_PC takes priority over POP_PC
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ie_PUSH_PC)     w_state_nxt = S_PUSH2;
        else if (ie_POP_PC) w_state_nxt = S_POP2;
      end
      S_PUSH2: w_state_nxt = S_IDLE;
      S_POP2:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath control; everything held inactive while rst is high
  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_sp;
    w_wdata   = ie_read_data1;
    w_sp_nxt  = r_sp;
    w_hi_ld   = 1'b0;
    w_stall   = 1'b0;
    w_ret_vld = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (ie_PUSH_PC) begin
            w_we     = 1'b1;
            w_wdata  = ie_PC[15:0];
            w_sp_nxt = w_sp_dec;
            w_stall  = 1'b1;
          end else if (ie_POP_PC) begin
            w_hi_ld  = 1'b1;
            w_sp_nxt = w_sp_inc;
            w_stall  = 1'b1;
          end else if (ie_STACK_SIGNAL) begin
            w_we = ie_MEM_Write;
            if (w_plain_push)     w_sp_nxt = w_sp_dec;
            else if (w_plain_pop) w_sp_nxt = w_sp_inc;
          end else begin
            w_we    = ie_MEM_Write;
            w_waddr = ie_result[ADDR_WIDTH-1:0];
          end
        end
        S_PUSH2: begin
          w_we     = 1'b1;
          w_wdata  = ie_PC[31:16];
          w_sp_nxt = w_sp_dec;
        end
        S_POP2: begin
          w_ret_vld = 1'b1;
          w_sp_nxt  = w_sp_inc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= SP_INIT;
      r_hi <= 16'h0;
    end else begin
      r_sp <= w_sp_nxt;
      if (w_hi_ld) r_hi <= w_rd_sp;
    end
  end

  // Data memory: no reset, synchronous write, asynchronous read
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign im_Rdst       = ie_Rdst;
  assign im_result     = ie_result;
  assign im_read_data  = r_mem[w_rd_addr];
  assign im_MEM_to_REG = ie_MEM_to_REG & ~w_stall & ~rst;
  assign im_WRITE_PORT = ie_WRITE_PORT & ~w_stall & ~rst;
  assign im_REG_Write  = ie_REG_Write  & ~w_stall & ~rst;
  assign mem_stall     = w_stall;
  assign ret_pc_valid  = w_ret_vld;
  assign ret_pc        = w_ret_vld ? {r_hi, w_rd_sp} : 32'h0;

endmodule
